// File: rtl/iob_soc_pbus_merge_if.sv
// iob_soc_pbus_merge_if
// One IOb-style native bus link between a requester and a responder.
//   valid/addr/wdata/wstrb : request, driven by the requester (wstrb==0 is a read)
//   ready                  : request acceptance, driven by the responder
//   rvalid/rdata           : read response, driven by the responder
// Modports: master = requester side, slave = responder side.
interface iob_soc_pbus_merge_if #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 32
);
    logic                  valid;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic                  ready;
    logic                  rvalid;
    logic [DATA_W-1:0]     rdata;

    modport master (
        output valid, addr, wdata, wstrb,
        input  ready, rvalid, rdata
    );

    modport slave (
        input  valid, addr, wdata, wstrb,
        output ready, rvalid, rdata
    );
endinterface

// File: rtl/iob_soc_pbus_merge.sv
// iob_soc_pbus_merge
// Merges four IOb manager ports onto one subordinate port with round-robin
// arbitration and a single outstanding transaction.
//   clk_i       : clock, rising edge
//   cke_i       : clock enable; 0 holds state, grant and pointer
//   rst_i       : synchronous active-high reset
//   input0..3_iob : manager-side links (slave modport)
//   output_iob  : subordinate-side link (master modport)
module iob_soc_pbus_merge #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 32
) (
    input  logic                         clk_i,
    input  logic                         cke_i,
    input  logic                         rst_i,
    iob_soc_pbus_merge_if.slave          input0_iob,
    iob_soc_pbus_merge_if.slave          input1_iob,
    iob_soc_pbus_merge_if.slave          input2_iob,
    iob_soc_pbus_merge_if.slave          input3_iob,
    iob_soc_pbus_merge_if.master         output_iob
);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        WAIT_RD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic [1:0]  ptr_q, ptr_d;

    // Manager ports gathered into arrays so the grant can index them.
    logic [3:0]         m_valid;
    logic [ADDR_W-1:0]  m_addr  [4];
    logic [DATA_W-1:0]  m_wdata [4];
    logic [STRB_W-1:0]  m_wstrb [4];
    logic [3:0]         m_ready;
    logic [3:0]         m_rvalid;
    logic [DATA_W-1:0]  m_rdata [4];

    assign m_valid  = {input3_iob.valid, input2_iob.valid, input1_iob.valid, input0_iob.valid};
    assign m_addr[0]  = input0_iob.addr;   assign m_addr[1]  = input1_iob.addr;
    assign m_addr[2]  = input2_iob.addr;   assign m_addr[3]  = input3_iob.addr;
    assign m_wdata[0] = input0_iob.wdata;  assign m_wdata[1] = input1_iob.wdata;
    assign m_wdata[2] = input2_iob.wdata;  assign m_wdata[3] = input3_iob.wdata;
    assign m_wstrb[0] = input0_iob.wstrb;  assign m_wstrb[1] = input1_iob.wstrb;
    assign m_wstrb[2] = input2_iob.wstrb;  assign m_wstrb[3] = input3_iob.wstrb;

    assign input0_iob.ready  = m_ready[0];   assign input1_iob.ready  = m_ready[1];
    assign input2_iob.ready  = m_ready[2];   assign input3_iob.ready  = m_ready[3];
    assign input0_iob.rvalid = m_rvalid[0];  assign input1_iob.rvalid = m_rvalid[1];
    assign input2_iob.rvalid = m_rvalid[2];  assign input3_iob.rvalid = m_rvalid[3];
    assign input0_iob.rdata  = m_rdata[0];   assign input1_iob.rdata  = m_rdata[1];
    assign input2_iob.rdata  = m_rdata[2];   assign input3_iob.rdata  = m_rdata[3];

    // Round-robin pick: scanning offsets from high to low lets the
    // requester closest to the pointer overwrite any farther one.
    logic [1:0] pick;
    always_comb begin
        pick = ptr_q;
        for (int i = 3; i >= 0; i--) begin
            if (m_valid[ptr_q + 2'(i)]) begin
                pick = ptr_q + 2'(i);
            end
        end
    end

    logic accept;
    logic is_read;
    assign accept  = (state_q == BUSY) && m_valid[grant_q] && output_iob.ready;
    assign is_read = (m_wstrb[grant_q] == '0);

    // State register
    always_ff @(posedge clk_i) begin
        if (cke_i) begin
            if (rst_i) begin
                state_q <= IDLE;
                grant_q <= 2'd0;
                ptr_q   <= 2'd0;
            end else begin
                state_q <= state_d;
                grant_q <= grant_d;
                ptr_q   <= ptr_d;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (|m_valid) begin
                    grant_d = pick;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (accept) begin
                    if (is_read) begin
                        state_d = WAIT_RD;
                    end else begin
                        state_d = IDLE;
                        ptr_d   = grant_q + 2'd1;
                    end
                end else if (!m_valid[grant_q]) begin
                    // Manager dropped its request before acceptance.
                    state_d = IDLE;
                end
            end
            WAIT_RD: begin
                if (output_iob.rvalid) begin
                    state_d = IDLE;
                    ptr_d   = grant_q + 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic; everything is forced low while reset is asserted so
    // nothing is accepted or forwarded in the reset cycle itself.
    always_comb begin
        output_iob.valid = 1'b0;
        output_iob.addr  = '0;
        output_iob.wdata = '0;
        output_iob.wstrb = '0;
        m_ready  = '0;
        m_rvalid = '0;
        for (int k = 0; k < 4; k++) begin
            m_rdata[k] = '0;
        end
        if (!rst_i) begin
            case (state_q)
                BUSY: begin
                    output_iob.valid  = m_valid[grant_q];
                    output_iob.addr   = m_addr[grant_q];
                    output_iob.wdata  = m_wdata[grant_q];
                    output_iob.wstrb  = m_wstrb[grant_q];
                    m_ready[grant_q]  = output_iob.ready;
                end
                WAIT_RD: begin
                    if (output_iob.rvalid) begin
                        m_rvalid[grant_q] = 1'b1;
                        m_rdata[grant_q]  = output_iob.rdata;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/iob_soc_pbus_merge.md
IOB_SOC_PBUS_MERGE -- requirements
Module: iob_soc_pbus_merge

Interface
REQ-001 Parameters SHALL be:
- ADDR_W, 28, address width of every port.
- DATA_W, 32, data width; wstrb width = DATA_W/8.
REQ-002 Ports SHALL be as follows; the K=0..3 lines define four identical manager-side ports:
- clk_i  in  1  sole clock, rising edge.
- cke_i  in  1  clock enable; 0 freezes all state.
- rst_i  in  1  synchronous, active-high reset.
- inputK_iob_valid_i  in  1  request from manager K.
- inputK_iob_addr_i  in  ADDR_W  address from manager K.
- inputK_iob_wdata_i  in  DATA_W  write data from manager K.
- inputK_iob_wstrb_i  in  DATA_W/8  byte strobes from manager K; 0 = read.
- inputK_iob_ready_o  out  1  request acceptance to manager K.
- inputK_iob_rvalid_o  out  1  read response valid to manager K.
- inputK_iob_rdata_o  out  DATA_W  read data to manager K.
- output_iob_valid_o / addr_o / wdata_o / wstrb_o  out  1/ADDR_W/DATA_W/DATA_W/8  request to subordinate.
- output_iob_ready_i / rvalid_i / rdata_i  in  1/1/DATA_W  subordinate handshake and response.

Function
REQ-003 A transaction is accepted in the cycle where output_iob_valid_o and output_iob_ready_i are both 1; it is a read if wstrb is 0, otherwise a write; only reads produce rvalid.
REQ-004 The state machine SHALL have states IDLE, BUSY and WAIT_RD, plus a 2-bit grant register and a 2-bit priority pointer.
REQ-005 IDLE: all outputs SHALL be 0. If any inputK_iob_valid_i is 1, the block SHALL:
- grant the first requester found scanning from pointer upward, modulo 4;
- register the grant and enter BUSY on the next edge.
REQ-006 BUSY:
- output_iob_valid_o/addr_o/wdata_o/wstrb_o SHALL equal the granted manager's inputs, combinationally.
- The granted manager's ready_o SHALL equal output_iob_ready_i; every other ready_o SHALL be 0.
REQ-007 BUSY exits:
- Accepted write: go to IDLE; pointer = grant+1 mod 4.
- Accepted read: go to WAIT_RD; pointer unchanged.
- Granted valid_i at 0 without acceptance (manager violation): go to IDLE; pointer unchanged.
REQ-008 WAIT_RD:
- output_iob_valid_o and all ready_o SHALL be 0.
- On output_iob_rvalid_i=1: the granted manager's rvalid_o=1 and rdata_o=output_iob_rdata_i in that same cycle; then go to IDLE with pointer = grant+1 mod 4.
REQ-009 rvalid_o and rdata_o of non-granted managers, and of all managers outside WAIT_RD, SHALL be 0; output_iob_rvalid_i outside WAIT_RD SHALL be ignored.
REQ-010 Latency:
- Request seen in IDLE at cycle t -> output_iob_valid_o at t+1.
- Minimum spacing between grants: 2 cycles for writes; 2 cycles plus subordinate read latency for reads.
- Only one transaction is outstanding at a time.
REQ-011 Requests arriving while BUSY or WAIT_RD are held off (ready_o=0) and compete at the next IDLE; the round-robin pointer guarantees each continuously requesting manager is granted within 4 transactions.
REQ-012 Address, data and strobes SHALL pass through unmodified at full width.
REQ-013 When cke_i=0, state, grant and pointer SHALL hold; combinational outputs SHALL follow the held state.

Reset
REQ-014 When rst_i=1 at a clock edge (cke_i=1), the block SHALL load state=IDLE, grant=0, pointer=0, regardless of current state.
REQ-015 In reset and immediately after, all outputs SHALL be 0.
REQ-016 A read abandoned by reset mid-WAIT_RD SHALL NOT be forwarded; a late output_iob_rvalid_i after reset SHALL be ignored.

Verification
REQ-017 Single write: input2 valid, addr=0x0000100, wdata=0xDEADBEEF, wstrb=0xF; subordinate ready=1 -> output request appears one cycle later carrying those exact values; input2_ready_o=1 in that cycle; IDLE follows; no rvalid is generated.
REQ-018 Read: input1 read at addr=0x0000040; subordinate ready=1, then rvalid=1 with rdata=0x12345678 three cycles later -> input1_rvalid_o=1 with rdata 0x12345678 in exactly that cycle; other rvalid_o stay 0.
REQ-019 Fairness: all four managers issue continuous writes from reset -> grant order is 0,1,2,3,0; each ready_o pulses once per 2 cycles of the round.
REQ-020 Backpressure: subordinate ready=0 for 5 cycles while input3 writes -> output fields remain stable; input3_ready_o=0; other managers are not granted; acceptance occurs on the first ready=1 cycle.
REQ-021 Reset in WAIT_RD: input0 read accepted, rst_i pulsed, then rvalid arrives -> all rvalid_o remain 0; the next grant goes to manager 0 (pointer reset).
REQ-022 cke_i=0 for 3 cycles during BUSY -> state and outputs frozen; the transaction completes normally once cke_i returns to 1.
